// File: rtl/traffic_light_ctrl_if.sv
// Bundle of demand inputs and light/status outputs between the host side and the sequencer.
interface traffic_light_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   req;
    logic                night;
    logic [3*NUM_CH-1:0] tl_export;
    logic [2:0]          cur_ch;
    logic [7:0]          remain;
    logic [2:0]          state;
    logic                phase_done;

    modport master (
        output req, night,
        input  tl_export, cur_ch, remain, state, phase_done
    );

    modport slave (
        input  req, night,
        output tl_export, cur_ch, remain, state, phase_done
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Green -> yellow -> all-red sequencer over NUM_CH approaches with demand skip,
// night flash mode and a per-state tick countdown.
module traffic_light_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    traffic_light_ctrl_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [2:0] ST_ALLRED = 3'd0;
    localparam logic [2:0] ST_GREEN  = 3'd1;
    localparam logic [2:0] ST_YELLOW = 3'd2;
    localparam logic [2:0] ST_FLASH  = 3'd3;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [7:0]    GREEN_LD  = 8'(GREEN_T);
    localparam logic [7:0]    YELLOW_LD = 8'(YELLOW_T);
    localparam logic [7:0]    ALLRED_LD = 8'(ALLRED_T);

    logic [2:0]          st;
    logic [2:0]          ch;
    logic [7:0]          rem;
    logic [PW-1:0]       presc;
    logic                flash_on;
    logic                pd;
    logic                tick;
    logic                expire;
    logic [3*NUM_CH-1:0] lights;

    assign tick   = (presc == PRESC_MAX);
    assign expire = tick && (rem == 8'd1);

    // Circular scan starting after cur; with no demand this degenerates to cur+1.
    function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [NUM_CH-1:0] r);
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = (int'(cur) >= NUM_CH - 1) ? 3'd0 : cur + 3'd1;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(cur) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && r[idx[IW-1:0]]) begin
                sel   = 3'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            st       <= ST_ALLRED;
            rem      <= ALLRED_LD;
            presc    <= '0;
            ch       <= 3'(NUM_CH - 1);
            flash_on <= 1'b0;
            pd       <= 1'b0;
        end else begin
            pd    <= 1'b0;
            presc <= tick ? '0 : presc + PRESC_ONE;
            case (st)
                ST_GREEN: begin
                    // Night truncates green immediately; also covers normal expiry.
                    if (bus.night || expire) begin
                        st    <= ST_YELLOW;
                        rem   <= YELLOW_LD;
                        presc <= '0;
                        pd    <= 1'b1;
                    end else if (tick) begin
                        rem <= rem - 8'd1;
                    end
                end
                ST_YELLOW: begin
                    if (expire) begin
                        st    <= ST_ALLRED;
                        rem   <= ALLRED_LD;
                        presc <= '0;
                        pd    <= 1'b1;
                    end else if (tick) begin
                        rem <= rem - 8'd1;
                    end
                end
                ST_ALLRED: begin
                    if (expire) begin
                        presc <= '0;
                        pd    <= 1'b1;
                        if (bus.night) begin
                            st       <= ST_FLASH;
                            rem      <= 8'd0;
                            flash_on <= 1'b1;
                        end else begin
                            st  <= ST_GREEN;
                            rem <= GREEN_LD;
                            ch  <= next_ch(ch, bus.req);
                        end
                    end else if (tick) begin
                        rem <= rem - 8'd1;
                    end
                end
                ST_FLASH: begin
                    if (!bus.night) begin
                        st    <= ST_ALLRED;
                        rem   <= ALLRED_LD;
                        presc <= '0;
                        pd    <= 1'b1;
                    end else if (tick) begin
                        flash_on <= ~flash_on;
                    end
                end
                default: begin
                    st    <= ST_ALLRED;
                    rem   <= ALLRED_LD;
                    presc <= '0;
                end
            endcase
        end
    end

    // Lights decode purely from registered state, so no transient codes at edges.
    always_comb begin
        lights = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (st == ST_FLASH)
                lights[3*k+1] = flash_on;
            else if (st == ST_GREEN && int'(ch) == k)
                lights[3*k] = 1'b1;
            else if (st == ST_YELLOW && int'(ch) == k)
                lights[3*k+1] = 1'b1;
            else
                lights[3*k+2] = 1'b1;
        end
    end

    assign bus.tl_export  = lights;
    assign bus.cur_ch     = ch;
    assign bus.remain     = rem;
    assign bus.state      = st;
    assign bus.phase_done = pd;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench: vector table for the free-running and demand cycles, hand sequences
// for countdown, night entry/exit and asynchronous reset.
module tb_traffic_light_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pd_cnt;

    traffic_light_ctrl_if #(.NUM_CH(4)) bus ();

    traffic_light_ctrl #(
        .NUM_CH(4), .TICK_DIV(4), .GREEN_T(5), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .bus(bus.slave)
    );

    typedef struct {
        int         adv;
        logic [3:0] req;
        logic       night;
        logic [2:0] st;
        logic [2:0] cur;
        logic [7:0] rem;
        logic [11:0] tl;
        logic       pd;
    } vec_t;

    vec_t tbl [20];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.phase_done === 1'b1) pd_cnt <= pd_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [2:0] cur,
                             input logic [7:0] rem, input logic [11:0] tl, input logic pd);
        check($sformatf("%s state", tag), 32'(bus.state), 32'(st));
        check($sformatf("%s cur_ch", tag), 32'(bus.cur_ch), 32'(cur));
        check($sformatf("%s remain", tag), 32'(bus.remain), 32'(rem));
        check($sformatf("%s tl_export", tag), 32'(bus.tl_export), 32'(tl));
        check($sformatf("%s phase_done", tag), 32'(bus.phase_done), 32'(pd));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pd_cnt = 0;
        bus.req   = 4'b0000;
        bus.night = 1'b0;
        rst_n     = 1'b0;

        // adv, req, night, state, cur_ch, remain, tl_export, phase_done
        tbl[0]  = '{0,  4'b0000, 1'b0, 3'd0, 3'd3, 8'd1, 12'h924, 1'b0};
        tbl[1]  = '{3,  4'b0000, 1'b0, 3'd0, 3'd3, 8'd1, 12'h924, 1'b0};
        tbl[2]  = '{1,  4'b0000, 1'b0, 3'd1, 3'd0, 8'd5, 12'h921, 1'b1};
        tbl[3]  = '{1,  4'b0000, 1'b0, 3'd1, 3'd0, 8'd5, 12'h921, 1'b0};
        tbl[4]  = '{3,  4'b0000, 1'b0, 3'd1, 3'd0, 8'd4, 12'h921, 1'b0};
        tbl[5]  = '{15, 4'b0000, 1'b0, 3'd1, 3'd0, 8'd1, 12'h921, 1'b0};
        tbl[6]  = '{1,  4'b0000, 1'b0, 3'd2, 3'd0, 8'd2, 12'h922, 1'b1};
        tbl[7]  = '{4,  4'b0000, 1'b0, 3'd2, 3'd0, 8'd1, 12'h922, 1'b0};
        tbl[8]  = '{4,  4'b0000, 1'b0, 3'd0, 3'd0, 8'd1, 12'h924, 1'b1};
        tbl[9]  = '{4,  4'b0000, 1'b0, 3'd1, 3'd1, 8'd5, 12'h90C, 1'b1};
        tbl[10] = '{20, 4'b0000, 1'b0, 3'd2, 3'd1, 8'd2, 12'h914, 1'b1};
        tbl[11] = '{12, 4'b0000, 1'b0, 3'd1, 3'd2, 8'd5, 12'h864, 1'b1};
        tbl[12] = '{32, 4'b0000, 1'b0, 3'd1, 3'd3, 8'd5, 12'h324, 1'b1};
        tbl[13] = '{20, 4'b0000, 1'b0, 3'd2, 3'd3, 8'd2, 12'h524, 1'b1};
        tbl[14] = '{12, 4'b0000, 1'b0, 3'd1, 3'd0, 8'd5, 12'h921, 1'b1};
        tbl[15] = '{12, 4'b1000, 1'b0, 3'd1, 3'd0, 8'd2, 12'h921, 1'b0};
        tbl[16] = '{20, 4'b1000, 1'b0, 3'd1, 3'd3, 8'd5, 12'h324, 1'b1};
        tbl[17] = '{32, 4'b0001, 1'b0, 3'd1, 3'd0, 8'd5, 12'h921, 1'b1};
        tbl[18] = '{32, 4'b0001, 1'b0, 3'd1, 3'd0, 8'd5, 12'h921, 1'b1};
        tbl[19] = '{32, 4'b0101, 1'b0, 3'd1, 3'd2, 8'd5, 12'h864, 1'b1};

        // Held in reset: outputs at their reset values.
        step(3);
        check_all("in_reset", 3'd0, 3'd3, 8'd1, 12'h924, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            bus.req   = tbl[i].req;
            bus.night = tbl[i].night;
            step(tbl[i].adv);
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].cur, tbl[i].rem, tbl[i].tl, tbl[i].pd);
        end

        // Countdown over the channel 2 green: 5,4,3,2,1 each for four clocks.
        bus.req = 4'b0000;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) step(1);
            check($sformatf("countdown%0d state", j), 32'(bus.state), 32'd1);
            check($sformatf("countdown%0d remain", j), 32'(bus.remain), 32'(5 - j / 4));
        end
        check("phase_done pulse count", 32'(pd_cnt), 32'd25);

        // Night raised on the third tick of the channel 3 green.
        step(25);
        check_all("green3_tick3", 3'd1, 3'd3, 8'd2, 12'h324, 1'b0);
        bus.night = 1'b1;
        step(1);
        check_all("night_yellow", 3'd2, 3'd3, 8'd2, 12'h524, 1'b1);
        step(4);
        check_all("night_yellow_r1", 3'd2, 3'd3, 8'd1, 12'h524, 1'b0);
        step(4);
        check_all("night_allred", 3'd0, 3'd3, 8'd1, 12'h924, 1'b1);
        step(4);
        check_all("flash_enter", 3'd3, 3'd3, 8'd0, 12'h492, 1'b1);
        step(3);
        check_all("flash_on_hold", 3'd3, 3'd3, 8'd0, 12'h492, 1'b0);
        step(1);
        check_all("flash_off", 3'd3, 3'd3, 8'd0, 12'h000, 1'b0);
        step(4);
        check_all("flash_on_again", 3'd3, 3'd3, 8'd0, 12'h492, 1'b0);

        // Night released in flash.
        bus.night = 1'b0;
        step(1);
        check_all("night_exit_allred", 3'd0, 3'd3, 8'd1, 12'h924, 1'b1);
        step(3);
        check_all("night_exit_hold", 3'd0, 3'd3, 8'd1, 12'h924, 1'b0);
        step(1);
        check_all("night_exit_green", 3'd1, 3'd0, 8'd5, 12'h921, 1'b1);

        // Asynchronous reset pulsed between edges during yellow.
        step(20);
        check_all("pre_reset_yellow", 3'd2, 3'd0, 8'd2, 12'h922, 1'b1);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 3'd0, 3'd3, 8'd1, 12'h924, 1'b0);
        #1;
        rst_n = 1'b1;
        step(4);
        check_all("after_reset_green", 3'd1, 3'd0, 8'd5, 12'h921, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
